div_int_restore: RTL and testbench

- Iterative signed 32-bit integer divider, the inverse companion of the team's radix-4 Booth multiplier in the integer arithmetic unit.
- Computes quotient and remainder of a / b, one quotient bit per clock, using restoring division on magnitudes followed by a sign-fixup cycle.
- Uses a start/busy/done handshake and flags divide-by-zero and signed overflow, so the ALU sequencer can issue back-to-back operations.

---
 rtl/div_int_restore.sv | 146 ++++++++++++++
 tb/tb_div_int_restore.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_int_restore.sv
// Iterative signed restoring divider: one quotient bit per clock on operand
// magnitudes, then a single fixup cycle that applies signs and special cases.
module div_int_restore #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Magnitude as unsigned WIDTH bits, so MIN_INT maps cleanly to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] f_neg_if(input logic neg,
                                                 input logic [WIDTH-1:0] x);
    return neg ? -x : x;
  endfunction

  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_a;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz_case;
  logic             r_ov_case;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;
  logic             r_ov;

  logic             w_b_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_sub_ok;

  assign w_b_zero = (b == '0);
  assign w_ovf    = (a == MIN_INT) && (b == '1);
  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};
  assign w_sub_ok = ~w_trial[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (w_b_zero || w_ovf) ? S_FIX : S_RUN;
      S_RUN:  if (r_cnt == LAST_CNT) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_dz   <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) r_busy <= 1'b1;
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_dz   <= r_dz_case;
          r_ov   <= r_ov_case;
          if (r_dz_case) begin
            r_q <= '1;
            r_r <= r_a;
          end else if (r_ov_case) begin
            r_q <= MIN_INT;
            r_r <= '0;
          end else begin
            r_q <= f_neg_if(r_sa ^ r_sb, r_dvd);
            r_r <= f_neg_if(r_sa, r_rem);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: quotient bits shift into r_dvd as dividend bits shift out.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (start) begin
        r_sa      <= a[WIDTH-1];
        r_sb      <= b[WIDTH-1];
        r_a       <= a;
        r_dvd     <= f_mag(a);
        r_div     <= f_mag(b);
        r_rem     <= '0;
        r_cnt     <= '0;
        r_dz_case <= w_b_zero;
        r_ov_case <= w_ovf && !w_b_zero;
      end
      S_RUN: begin
        r_rem <= w_sub_ok ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        r_dvd <= {r_dvd[WIDTH-2:0], w_sub_ok};
        r_cnt <= r_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign q        = r_q;
  assign r        = r_r;
  assign div_zero = r_dz;
  assign overflow = r_ov;

endmodule

// File: tb/tb_div_int_restore.sv
// Bench for div_int_restore: cycle-level reference model plus directed vectors
// with literal expected results.
module tb_div_int_restore;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero, overflow;
  logic [W-1:0] q, r;

  div_int_restore #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference arithmetic: signed division truncating toward zero.
  task automatic model_div(input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] mq, output logic [W-1:0] mr,
                           output logic mdz, output logic mov);
    longint sx, sy, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    mdz = 1'b0;
    mov = 1'b0;
    if (y == '0) begin
      mq = '1; mr = x; mdz = 1'b1;
    end else if (x == MIN_INT && y == '1) begin
      mq = MIN_INT; mr = '0; mov = 1'b1;
    end else begin
      qq = sx / sy;
      rr = sx % sy;
      mq = W'(qq);
      mr = W'(rr);
    end
  endtask

  // Cycle model: an accepted operation completes a fixed number of edges later.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_ov = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic [W-1:0] p_q, p_r;
  logic         p_dz, p_ov;
  bit           m_pend = 1'b0;
  bit           m_valid = 1'b0;
  int           cyc = 0;
  int           m_due = 0;

  always @(posedge clk) begin
    cyc++;
    m_valid = 1'b1;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_q = '0; m_r = '0;
      m_dz = 1'b0; m_ov = 1'b0; m_pend = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        if (cyc == m_due) begin
          m_done = 1'b1; m_busy = 1'b0; m_pend = 1'b0;
          m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
        end
      end else if (start) begin
        model_div(a, b, p_q, p_r, p_dz, p_ov);
        m_due  = cyc + ((p_dz || p_ov) ? 1 : W + 1);
        m_pend = 1'b1;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model busy", W'(busy), W'(m_busy));
      check("model done", W'(done), W'(m_done));
      check("model q", q, m_q);
      check("model r", r, m_r);
      check("model div_zero", W'(div_zero), W'(m_dz));
      check("model overflow", W'(overflow), W'(m_ov));
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov, input int elat, input int ign_at);
    int lat, nb;
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      if (lat == ign_at) begin a = 32'd55; b = 32'd5; start = 1'b1; end
      @(negedge clk);
      if (lat == ign_at) start = 1'b0;
      lat++;
    end
    check({tag, " done"}, W'(done), W'(1'b1));
    check({tag, " latency"}, W'(lat), W'(elat));
    check({tag, " busy cycles"}, W'(nb), W'(elat));
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " div_zero"}, W'(div_zero), W'(edz));
    check({tag, " overflow"}, W'(overflow), W'(eov));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset q", q, '0);
    check("reset r", r, '0);
    check("reset flags", W'({div_zero, overflow}), '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("100/7",    32'd100,        32'd7,          32'd14,         32'd2,          0, 0, 33, -1);
    run_op("-100/7",   -32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  0, 0, 33, -1);
    run_op("100/-7",   32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          0, 0, 33, -1);
    run_op("-100/-7",  -32'sd100,      -32'sd7,        32'd14,         32'hFFFF_FFFE,  0, 0, 33, -1);
    run_op("5/0",      32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1, 0, 1,  -1);
    run_op("MIN/-1",   MIN_INT,        32'hFFFF_FFFF,  MIN_INT,        32'd0,          0, 1, 1,  -1);
    run_op("-5/0",     -32'sd5,        32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1, 0, 1,  -1);
    run_op("MIN/3",    MIN_INT,        32'd3,          32'hD555_5556,  32'hFFFF_FFFE,  0, 0, 33, -1);
    run_op("MIN/1",    MIN_INT,        32'd1,          MIN_INT,        32'd0,          0, 0, 33, -1);
    run_op("0/5",      32'd0,          32'd5,          32'd0,          32'd0,          0, 0, 33, -1);
    run_op("1000/3 ignore start", 32'd1000, 32'd3,     32'd333,        32'd1,          0, 0, 33, 10);
    run_op("7/2 back-to-back", 32'd7,  32'd2,          32'd3,          32'd1,          0, 0, 33, -1);

    // Abort an operation mid-flight with reset.
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", W'(busy), '0);
    check("abort q", q, '0);
    check("abort r", r, '0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no done", W'(seen), '0);
    run_op("after abort -100/-7", -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 0, 0, 33, -1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
